// File: rtl/clk_div_pkg.sv
// Shared definitions for the N-way clock divider: run states, the smallest
// divisor that can be loaded, and the default divisor width.
package clk_div_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DIV_MIN       = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/clk_ndiv_outstage.sv
// Output stage of the divider. The posedge phase bit is retimed onto the
// falling edge so odd divisors get a half-cycle-accurate 50% duty, then the
// registered odd/even select picks the plain or the AND-ed phase.
module clk_ndiv_outstage (
    input  logic clk,
    input  logic reset,
    input  logic pos_in,
    input  logic odd_sel,
    output logic clk_out
);

    logic neg_d;
    logic neg_q;

    // Falling-edge copy of the posedge phase bit
    always_comb begin
        neg_d = pos_in;
    end

    // Negedge retiming flop, cleared asynchronously with the rest of the divider
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    // Even divisors pass the phase straight through; odd divisors delay the
    // rising edge by half a cycle. Both inputs are flops and are low at every
    // period boundary, so the select switches while the output is low.
    assign clk_out = pos_in & (neg_q | ~odd_sel);

endmodule

// File: rtl/clk_ndiv.sv
// Programmable integer clock divider. A counter runs 0..N-1 while enabled,
// a phase bit marks the first ceil(N/2) cycles of each period, and the output
// stage turns that into a divided clock with N/2-cycle high time. New divisors
// are held in a pending register and only take effect at a period boundary.
import clk_div_pkg::*;

module clk_ndiv #(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic [WIDTH-1:0] div_active,
    output logic             load_ack,
    output logic             load_err,
    output logic             tick
);

    localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_N = WIDTH'(DIV_MIN);

    // ceil(n/2) evaluated one bit wider so n = 2^WIDTH-1 does not wrap
    function automatic logic [WIDTH:0] half_of(input logic [WIDTH-1:0] n);
        return ({1'b0, n} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    endfunction

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] active_q,  active_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             pend_v_q,  pend_v_d;
    logic             ack_q,     ack_d;
    logic             err_q,     err_d;
    logic             pos_q,     pos_d;
    logic             tick_q,    tick_d;
    logic             odd_q,     odd_d;

    logic             accept;
    logic             term;

    assign accept = div_load && (div_val >= MIN_N);
    assign term   = (state_q == RUN) && (cnt_q == active_q - 1'b1);

    // Next-state logic: run FSM, period counter and divisor load/apply path
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;

        if (accept) begin
            pending_d = div_val;
            pend_v_d  = 1'b1;
        end else if (div_load) begin
            err_d = 1'b1;
        end

        // A load in the same cycle as the boundary is already in pending_d,
        // so it takes effect at this boundary; the last accepted value wins.
        if (pend_v_d && ((state_q == IDLE) || term)) begin
            active_d = pending_d;
            pend_v_d = 1'b0;
            ack_d    = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (term) begin
                    cnt_d = '0;
                    if (!en) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs derived from the upcoming cycle's count and divisor
    always_comb begin
        pos_d  = (state_d == RUN) && ({1'b0, cnt_d} < half_of(active_d));
        tick_d = (state_d == RUN) && (cnt_d == '0);
        odd_d  = active_d[0];
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            active_q  <= DEF_N;
            pending_q <= DEF_N;
            pend_v_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            pos_q     <= 1'b0;
            tick_q    <= 1'b0;
            odd_q     <= DEF_N[0];
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pend_v_q  <= pend_v_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            pos_q     <= pos_d;
            tick_q    <= tick_d;
            odd_q     <= odd_d;
        end
    end

    clk_ndiv_outstage u_outstage (
        .clk     (clk),
        .reset   (reset),
        .pos_in  (pos_q),
        .odd_sel (odd_q),
        .clk_out (clk_out)
    );

    assign div_active = active_q;
    assign load_ack   = ack_q;
    assign load_err   = err_q;
    assign tick       = tick_q;

endmodule
